pipe_skid_stage: RTL
====================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning payload width in bits (stage payload, e.g. packed control word plus data fields).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-003 The block SHALL have port clk, input, 1, meaning clock; all state updates on posedge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, synchronous, active-high.
REQ-005 The block SHALL have port flush, input, 1, meaning synchronous kill of all held entries (branch mispredict).
REQ-006 The block SHALL have port in_valid, input, 1, meaning upstream payload valid.
REQ-007 The block SHALL have port in_ready, output, 1, meaning block can accept this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH, meaning upstream payload.
REQ-009 The block SHALL have port out_valid, output, 1, meaning out_data holds a live entry.
REQ-010 The block SHALL have port out_ready, input, 1, meaning downstream accepts (deasserted = stall).
REQ-011 The block SHALL have port out_data, output, WIDTH, meaning oldest held payload.
REQ-012 The block SHALL have port occupancy, output, 2, meaning number of held entries, 0..2.
REQ-013 The block SHALL have port stall_cnt, output, CNT_W, meaning count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 The block SHALL hold two WIDTH-bit registers, main and skid, with a state machine EMPTY (0 entries), BUSY (main live), FULL (main+skid live).
REQ-015 in_ready SHALL be a registered signal equal to (state != FULL); no combinational path from out_ready to in_ready.
REQ-016 in_fire SHALL be in_valid & in_ready; out_fire SHALL be out_valid & out_ready; out_valid SHALL be (state != EMPTY); out_data SHALL be main.
REQ-017 In EMPTY with in_fire, the block SHALL load main<=in_data and go to BUSY; out_valid rises the next cycle (latency 1).
REQ-018 In BUSY with in_fire and out_fire, the block SHALL load main<=in_data and stay BUSY (full throughput).
REQ-019 In BUSY with in_fire only, the block SHALL load skid<=in_data and go to FULL.
REQ-020 In BUSY with out_fire only, the block SHALL go to EMPTY.
REQ-021 In FULL with out_fire, the block SHALL load main<=skid and go to BUSY; in_ready reasserts the next cycle.
REQ-022 In FULL without out_fire, all registers SHALL hold.
REQ-023 Entries SHALL leave in arrival order; no payload SHALL be dropped or duplicated.
REQ-024 Flush SHALL take priority over all handshakes: next state EMPTY, in_ready=1, occupancy=0.
REQ-025 An in_data presented in the same cycle as flush SHALL be discarded.
REQ-026 On flush, main and skid contents SHALL be don't-care; out_valid=0 masks them.
REQ-027 occupancy SHALL equal 0/1/2 for EMPTY/BUSY/FULL.
REQ-028 stall_cnt SHALL increment by 1 per stall cycle and saturate at 2^CNT_W-1 (no wrap).
REQ-029 flush SHALL NOT clear stall_cnt.

Reset
REQ-030 On rst, state SHALL be EMPTY, main=0, skid=0, in_ready=1, out_valid=0, out_data=0, occupancy=0, stall_cnt=0.
REQ-031 rst SHALL override flush and any in-flight handshake, including mid-FULL.
REQ-032 The first accept SHALL be possible in the cycle after rst deasserts.

Structure
REQ-033 The state enum pipe_skid_state_t {EMPTY, BUSY, FULL} SHALL be defined in rv32i_types.
REQ-034 Payload structs SHALL be defined in rv32i_types and passed flattened via WIDTH.
REQ-035 The block SHALL be a single flat module with no sub-module; the counter is inline.
REQ-036 One instance SHALL replace each fixed inter-stage register (IF/ID .. MEM/WB).

Verification (WIDTH=32, CNT_W=4)
REQ-037 Streaming: out_ready=1, in_valid=1 with data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 one cycle later, one per cycle, occupancy stays 1.
REQ-038 Backpressure: accept 0xA then 0xB with out_ready=0 -> FULL, in_ready=0, 0xC held off; release out_ready -> 0xA, 0xB, 0xC in order.
REQ-039 Flush in FULL with in_valid=1, in_data=0xD -> next cycle out_valid=0, occupancy=0, in_ready=1, 0xD never appears.
REQ-040 Counter saturation: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and holds; flush -> still 15; rst -> 0.
REQ-041 Reset mid-operation: rst asserted in FULL -> next cycle all outputs at reset values; accept 0x5 the cycle after rst drops -> out_data=0x5 next cycle.
REQ-042 Random valid/ready over 10k cycles with a scoreboard -> in-order delivery, no loss or duplication, and in_ready never combinationally depends on out_ready.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the rv32i pipeline: the skid-stage state encoding and the
// inter-stage payload records that are flattened onto the stage WIDTH.
package rv32i_types;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_skid_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        wb_en;
  } mem_wb_t;

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline register with flush and a saturating stall counter.
// in_ready is registered, so upstream never sees a combinational path from out_ready.
module pipe_skid_stage
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  pipe_skid_state_t state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             in_fire;
  logic             out_fire;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign stall_cnt = stall_cnt_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      // Counts every stalled cycle, flush cycles included; only rst clears it.
      if (out_valid && !out_ready && stall_cnt_q != CntMax) begin
        stall_cnt_q <= stall_cnt_q + CntOne;
      end
      if (flush) begin
        state_q    <= EMPTY;
        in_ready_q <= 1'b1;
      end else begin
        case (state_q)
          EMPTY: begin
            if (in_fire) begin
              main_q  <= in_data;
              state_q <= BUSY;
            end
          end
          BUSY: begin
            if (in_fire && out_fire) begin
              main_q <= in_data;
            end else if (in_fire) begin
              skid_q     <= in_data;
              state_q    <= FULL;
              in_ready_q <= 1'b0;
            end else if (out_fire) begin
              state_q <= EMPTY;
            end
          end
          FULL: begin
            if (out_fire) begin
              main_q     <= skid_q;
              state_q    <= BUSY;
              in_ready_q <= 1'b1;
            end
          end
          default: begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
